// File: rtl/branch_pkg.sv
// Shared types for the branch arbiter: branch type encoding and FSM states.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Purely combinational branch condition evaluator: type plus two operands in, taken out.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  br_type_e          br_type,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = (op_a == op_b);
            BR_BNE:  taken = (op_a != op_b);
            BR_BLT:  taken = ($signed(op_a) <  $signed(op_b));
            BR_BGE:  taken = ($signed(op_a) >= $signed(op_b));
            BR_BLTU: taken = (op_a <  op_b);
            BR_BGEU: taken = (op_a >= op_b);
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_arbiter.sv
// Two-requester round-robin branch resolver: accept one request, evaluate it
// for a cycle, then hold the response until the consumer takes it.
module branch_arbiter
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][2:0]        req_type,
    input  logic [1:0][XLEN-1:0]   req_op_a,
    input  logic [1:0][XLEN-1:0]   req_op_b,
    input  logic [1:0][XLEN-1:0]   req_target,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic                   resp_taken,
    output logic [XLEN-1:0]        resp_target,
    output logic [CNT_W-1:0]       taken_count
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    br_type_e          type_q, type_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              id_q, id_d;
    logic              taken_q, taken_d;
    logic [XLEN-1:0]   resp_target_q, resp_target_d;
    logic [CNT_W-1:0]  taken_count_q, taken_count_d;
    logic              cmp_taken;
    logic              grant_idx;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .br_type (type_q),
        .op_a    (op_a_q),
        .op_b    (op_b_q),
        .taken   (cmp_taken)
    );

    // Grant is a function of state, last_grant and req_valid only, so the
    // consumer's resp_ready can never reach back into req_ready.
    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant_q ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign grant_idx = req_ready[1];

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        type_d        = type_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        target_d      = target_q;
        id_d          = id_q;
        taken_d       = taken_q;
        resp_target_d = resp_target_q;
        taken_count_d = taken_count_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    type_d       = br_type_e'(req_type[grant_idx]);
                    op_a_d       = req_op_a[grant_idx];
                    op_b_d       = req_op_b[grant_idx];
                    target_d     = req_target[grant_idx];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                taken_d       = cmp_taken;
                resp_target_d = cmp_taken ? target_q : '0;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    if (taken_q && !(&taken_count_q)) begin
                        taken_count_d = taken_count_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset also drops any in-flight request without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            type_q        <= BR_NONE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            target_q      <= '0;
            id_q          <= 1'b0;
            taken_q       <= 1'b0;
            resp_target_q <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            type_q        <= type_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            target_q      <= target_d;
            id_q          <= id_d;
            taken_q       <= taken_d;
            resp_target_q <= resp_target_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign resp_valid  = (state_q == ST_RESP);
    assign resp_id     = id_q;
    assign resp_taken  = taken_q;
    assign resp_target = resp_target_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_arbiter.sv
// Directed and randomized checks of branch_arbiter against a transaction-level
// model of grant order, branch outcome and the saturating taken counter.
module tb_branch_arbiter;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][2:0]       req_type;
    logic [1:0][XLEN-1:0]  req_op_a;
    logic [1:0][XLEN-1:0]  req_op_b;
    logic [1:0][XLEN-1:0]  req_target;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic                  resp_taken;
    logic [XLEN-1:0]       resp_target;
    logic [CNT_W-1:0]      taken_count;

    int total = 0;
    int bad   = 0;
    int expLastGrant;
    int expCount;

    branch_arbiter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .req_target  (req_target),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_taken  (resp_taken),
        .resp_target (resp_target),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    // Branch outcome from the architectural rules, using 64-bit arithmetic.
    function automatic bit refTaken(input logic [2:0] t, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (t)
            3'd1:    return ua == ub;
            3'd2:    return ua != ub;
            3'd3:    return sa < sb;
            3'd4:    return sa >= sb;
            3'd5:    return ua < ub;
            3'd6:    return ua >= ub;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] expGrant(input logic [1:0] v);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b11) return (expLastGrant == 1) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0][2:0] t,
                                 input logic [1:0][XLEN-1:0] a,
                                 input logic [1:0][XLEN-1:0] b,
                                 input logic [1:0][XLEN-1:0] tg);
        req_valid  = v;
        req_type   = t;
        req_op_a   = a;
        req_op_b   = b;
        req_target = tg;
    endtask

    task automatic scrambleInputs();
        for (int i = 0; i < 2; i++) begin
            req_type[i]   = 3'($urandom_range(0, 7));
            req_op_a[i]   = $urandom;
            req_op_b[i]   = $urandom;
            req_target[i] = $urandom;
        end
        req_valid = 2'($urandom_range(0, 3));
    endtask

    task automatic nextCycle(input bit scramble);
        @(posedge clk);
        #1;
        if (scramble) scrambleInputs();
        #1;
    endtask

    // One full request: grant, EVAL, RESP held for 'hold' cycles, handshake.
    task automatic runTxn(input logic [1:0] v, input logic [1:0][2:0] t,
                          input logic [1:0][XLEN-1:0] a,
                          input logic [1:0][XLEN-1:0] b,
                          input logic [1:0][XLEN-1:0] tg,
                          input int hold, input bit scramble);
        logic [1:0]      er;
        int              idx;
        bit              et;
        logic [XLEN-1:0] etg;
        applyStimulus(v, t, a, b, tg);
        resp_ready = 1'b0;
        #1;
        er = expGrant(v);
        checkOutput("grant", 64'(req_ready), 64'(er));
        if (er == 2'b00) begin
            nextCycle(1'b0);
            checkOutput("no_accept_valid", 64'(resp_valid), 64'd0);
            return;
        end
        idx = er[1] ? 1 : 0;
        et  = refTaken(t[idx], a[idx], b[idx]);
        etg = et ? tg[idx] : '0;
        expLastGrant = idx;

        nextCycle(scramble);
        checkOutput("eval_valid", 64'(resp_valid), 64'd0);
        checkOutput("eval_ready", 64'(req_ready), 64'd0);

        nextCycle(scramble);
        for (int k = 0; k <= hold; k++) begin
            checkOutput("resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("resp_id", 64'(resp_id), 64'(idx));
            checkOutput("resp_taken", 64'(resp_taken), 64'(et));
            checkOutput("resp_target", 64'(resp_target), 64'(etg));
            checkOutput("resp_ready_block", 64'(req_ready), 64'd0);
            if (k < hold) nextCycle(scramble);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        if (et && expCount < CNT_MAX) expCount++;
        #1;
        checkOutput("post_hs_valid", 64'(resp_valid), 64'd0);
        checkOutput("taken_count", 64'(taken_count), 64'(expCount));
    endtask

    task automatic doReset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_id", 64'(resp_id), 64'd0);
        checkOutput("rst_taken", 64'(resp_taken), 64'd0);
        checkOutput("rst_target", 64'(resp_target), 64'd0);
        checkOutput("rst_count", 64'(taken_count), 64'd0);
        rst = 1'b0;
        expLastGrant = 1;
        expCount     = 0;
    endtask

    initial begin
        logic [1:0][2:0]      t;
        logic [1:0][XLEN-1:0] a, b, tg;
        logic [1:0]           v;

        rst = 1'b1;
        req_valid = 2'b00; resp_ready = 1'b0;
        req_type = '0; req_op_a = '0; req_op_b = '0; req_target = '0;
        @(posedge clk);
        doReset();

        $display("[TB] BEQ single request");
        t = '0; a = '0; b = '0; tg = '0;
        t[0] = 3'd1; a[0] = 32'h5; b[0] = 32'h5; tg[0] = 32'h100;
        runTxn(2'b01, t, a, b, tg, 0, 1'b0);

        $display("[TB] alternating grants, BLT vs BLTU");
        doReset();
        t[0] = 3'd5; a[0] = 32'hFFFF_FFFF; b[0] = 32'h1; tg[0] = 32'h200;
        t[1] = 3'd3; a[1] = 32'hFFFF_FFFF; b[1] = 32'h1; tg[1] = 32'h300;
        for (int i = 0; i < 4; i++) runTxn(2'b11, t, a, b, tg, 0, 1'b0);

        $display("[TB] unconditional and none types");
        t[1] = 3'd7; a[1] = $urandom; b[1] = $urandom; tg[1] = 32'hABCD_0000;
        runTxn(2'b10, t, a, b, tg, 0, 1'b0);
        t[1] = 3'd0; a[1] = $urandom; b[1] = $urandom; tg[1] = 32'h1234_5678;
        runTxn(2'b10, t, a, b, tg, 0, 1'b0);

        $display("[TB] stalled response with changing inputs");
        t[0] = 3'd2; a[0] = 32'h7; b[0] = 32'h8; tg[0] = 32'h440;
        runTxn(2'b01, t, a, b, tg, 5, 1'b1);

        $display("[TB] reset during EVAL");
        doReset();
        t[0] = 3'd7; tg[0] = 32'h900;
        applyStimulus(2'b01, t, a, b, tg);
        #1;
        checkOutput("evrst_grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        checkOutput("evrst_valid", 64'(resp_valid), 64'd0);
        checkOutput("evrst_count", 64'(taken_count), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        #1;
        checkOutput("evrst_valid2", 64'(resp_valid), 64'd0);
        checkOutput("evrst_idle", 64'(req_ready), 64'd2);
        req_valid = 2'b00;
        expLastGrant = 1;
        expCount     = 0;
        runTxn(2'b11, t, a, b, tg, 1, 1'b0);

        $display("[TB] counter saturation");
        t[0] = 3'd7; t[1] = 3'd7;
        for (int i = 0; i < CNT_MAX + 3; i++) runTxn(2'b11, t, a, b, tg, 0, 1'b0);
        checkOutput("sat_count", 64'(taken_count), 64'(CNT_MAX));

        $display("[TB] randomized requests");
        doReset();
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                t[i]  = 3'($urandom_range(0, 7));
                a[i]  = $urandom;
                b[i]  = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
                tg[i] = $urandom;
            end
            v = 2'($urandom_range(0, 3));
            runTxn(v, t, a, b, tg, $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
